// File: rtl/line_mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// line_mem_responder_pkg
// Shared definitions for the line memory responder and its arbiter.
//   - `WORD_SIZE / `LINE_SIZE : word and line widths in bits (16 / 64)
//   - resp_state_t           : responder FSM states (IDLE / BUSY / RESP)
//   - port_id_t              : port identifiers (PORT_I / PORT_D)
// ---------------------------------------------------------------------------
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif
`ifndef LINE_SIZE
`define LINE_SIZE 64
`endif

package line_mem_responder_pkg;

    localparam int WORD_W     = `WORD_SIZE;
    localparam int LINE_W     = `LINE_SIZE;
    localparam int LINE_WORDS = LINE_W / WORD_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } resp_state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_id_t;

endpackage

// File: rtl/line_mem_responder_arb.sv
// ---------------------------------------------------------------------------
// mem_resp_arbiter
// Combinational grant between the I-port and D-port of the line responder.
// D wins when it is the only requester, or when both request and I was
// granted last time, so ties alternate and D takes the first tie.
// Ports:
//   i_req      in  I-port requesting (readM | writeM)
//   d_req      in  D-port requesting (readM | writeM)
//   last_grant in  port accepted by the previous transaction
//   grant      out port to accept if a request is taken this cycle
// ---------------------------------------------------------------------------
module mem_resp_arbiter
    import line_mem_responder_pkg::*;
(
    input  logic     i_req,
    input  logic     d_req,
    input  port_id_t last_grant,
    output port_id_t grant
);

    always_comb begin
        grant = PORT_I;
        if (d_req && (!i_req || (last_grant == PORT_I))) begin
            grant = PORT_D;
        end
    end

endmodule

// File: rtl/line_mem_responder.sv
// ---------------------------------------------------------------------------
// line_mem_responder
// Memory-side responder for the I-cache and D-cache line interfaces.
// Serves one 4-word line transaction at a time: accept in IDLE, wait in
// BUSY, then a single RESP cycle that pulses the granted port's ack and,
// for a read, drives that port's data bus with the line.
// Parameters:
//   MEM_LATENCY  cycles from acceptance to ack (>= 1; 1 skips BUSY)
//   MEM_WORDS    16-bit words in the array (power of two, >= 4, <= 65536)
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   i_address, i_readM, i_writeM   I-port word address and line requests
//   i_data                         I-port 64-bit bidirectional line bus
//   i_ack                          I-port one-cycle completion pulse
//   d_*                            same as the I-port, for the D-port
// Optional feature (macro MEM_RESP_STATS_EN):
//   i_txn_count, d_txn_count       saturating per-port completed counts
// ---------------------------------------------------------------------------
module line_mem_responder
    import line_mem_responder_pkg::*;
#(
    parameter int MEM_LATENCY = 4,
    parameter int MEM_WORDS   = 65536
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [15:0]       i_address,
    input  logic              i_readM,
    input  logic              i_writeM,
    inout  wire  [LINE_W-1:0] i_data,
    output logic              i_ack,
    input  logic [15:0]       d_address,
    input  logic              d_readM,
    input  logic              d_writeM,
    inout  wire  [LINE_W-1:0] d_data,
    output logic              d_ack
`ifdef MEM_RESP_STATS_EN
    ,
    output logic [15:0]       i_txn_count,
    output logic [15:0]       d_txn_count
`endif
);

    localparam int AW        = $clog2(MEM_WORDS);
    localparam int CNT_W     = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY) : 1;
    // BUSY lasts MEM_LATENCY-1 cycles; the counter ends at MEM_LATENCY-2.
    localparam int BUSY_LAST = (MEM_LATENCY > 1) ? (MEM_LATENCY - 2) : 0;

    resp_state_t          state_q;
    resp_state_t          state_d;
    port_id_t             last_grant_q;
    port_id_t             port_q;
    port_id_t             grant;
    logic                 write_q;
    logic [AW-1:0]        base_q;
    logic [LINE_W-1:0]    wdata_q;
    logic [LINE_W-1:0]    line_q;
    logic [CNT_W-1:0]     lat_cnt_q;
    logic [WORD_W-1:0]    mem [MEM_WORDS];

    logic                 i_req;
    logic                 d_req;
    logic                 any_req;
    logic [15:0]          acc_addr;
    logic [AW-1:0]        acc_base;
    logic                 acc_write;
    logic [LINE_W-1:0]    acc_wdata;
    logic [AW-1:0]        rd_base;
    logic                 rd_op;
    logic                 load_line;

    assign i_req   = i_readM | i_writeM;
    assign d_req   = d_readM | d_writeM;
    assign any_req = i_req | d_req;

    mem_resp_arbiter u_arb (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    // Request as seen through the granted port. Address bits above the array
    // size are dropped and the low two bits cleared to get the line base.
    // readM together with writeM is a write.
    assign acc_addr  = (grant == PORT_D) ? d_address : i_address;
    assign acc_base  = acc_addr[AW-1:0] & ~AW'(3);
    assign acc_write = (grant == PORT_D) ? d_writeM : i_writeM;
    assign acc_wdata = (grant == PORT_D) ? d_data : i_data;

    // Next-state logic. With MEM_LATENCY=1 the accept edge goes straight to RESP.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = (MEM_LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                if (lat_cnt_q == CNT_W'(BUSY_LAST)) begin
                    state_d = RESP;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register plus transaction latch. Reset drops any in-flight
    // transaction, so a pending write never reaches the array.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= PORT_I;
            port_q       <= PORT_I;
            write_q      <= 1'b0;
            base_q       <= '0;
            wdata_q      <= '0;
            lat_cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        port_q       <= grant;
                        last_grant_q <= grant;
                        write_q      <= acc_write;
                        base_q       <= acc_base;
                        wdata_q      <= acc_wdata;
                        lat_cnt_q    <= '0;
                    end
                end
                BUSY: lat_cnt_q <= lat_cnt_q + CNT_W'(1);
                default: ;
            endcase
        end
    end

    // The line register is loaded on the edge that enters RESP. When BUSY is
    // skipped that edge is also the accept edge, so the base comes straight
    // from the incoming request.
    assign rd_base   = (state_q == IDLE) ? acc_base : base_q;
    assign rd_op     = (state_q == IDLE) ? !acc_write : !write_q;
    assign load_line = reset_n && (state_d == RESP) && (state_q != RESP) && rd_op;

    // Array and line register carry no reset; a write commits on the edge
    // closing its RESP cycle.
    always_ff @(posedge clk) begin
        if (load_line) begin
            for (int k = 0; k < LINE_WORDS; k++) begin
                line_q[k*WORD_W +: WORD_W] <= mem[rd_base + AW'(k)];
            end
        end
        if ((state_q == RESP) && write_q) begin
            for (int k = 0; k < LINE_WORDS; k++) begin
                mem[base_q + AW'(k)] <= wdata_q[k*WORD_W +: WORD_W];
            end
        end
    end

    assign i_ack  = (state_q == RESP) && (port_q == PORT_I);
    assign d_ack  = (state_q == RESP) && (port_q == PORT_D);
    assign i_data = (i_ack && !write_q) ? line_q : 'z;
    assign d_data = (d_ack && !write_q) ? line_q : 'z;

`ifdef MEM_RESP_STATS_EN
    logic [15:0] i_cnt_q;
    logic [15:0] d_cnt_q;

    // Completed-transaction counters, bumped in RESP and pinned at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i_cnt_q <= '0;
            d_cnt_q <= '0;
        end else if (state_q == RESP) begin
            if ((port_q == PORT_I) && (i_cnt_q != 16'hFFFF)) begin
                i_cnt_q <= i_cnt_q + 16'd1;
            end
            if ((port_q == PORT_D) && (d_cnt_q != 16'hFFFF)) begin
                d_cnt_q <= d_cnt_q + 16'd1;
            end
        end
    end

    assign i_txn_count = i_cnt_q;
    assign d_txn_count = d_cnt_q;
`endif

endmodule
